wb_dshot_tx: RTL

Wishbone slave that drives the quad's ESCs with DSHOT frames. It sits directly downstream of the SPI-to-Wishbone bridge: it consumes the bridge's single-beat register writes and reads, and turns each motor-register write into one 16-bit DSHOT frame on that motor's output pin. CRC generation, bit timing, inter-frame guard time and pending-update queuing are all done in hardware.

---
 rtl/dshot_pkg.sv | 27 ++
 rtl/dshot_channel.sv | 137 +++++++++++++
 rtl/wb_dshot_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/dshot_pkg.sv
// Shared constants, Wishbone request bundle and the DSHOT checksum
// used by the DSHOT transmitter and its per-motor channels.
package dshot_pkg;

  localparam int FRAME_W = 16;
  localparam int VALUE_W = 12;

  localparam logic [2:0] REG_MOTOR0 = 3'd0;
  localparam logic [2:0] REG_MOTOR1 = 3'd1;
  localparam logic [2:0] REG_MOTOR2 = 3'd2;
  localparam logic [2:0] REG_MOTOR3 = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // Only the fields the register file actually consumes are carried.
  typedef struct packed {
    logic               we;
    logic [2:0]         idx;
    logic [1:0]         sel;
    logic [VALUE_W-1:0] dat;
  } wb_req_t;

  // crc = (v ^ v>>4 ^ v>>8) & 0xF, i.e. XOR of the three nibbles.
  function automatic logic [3:0] dshot_crc(input logic [VALUE_W-1:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/dshot_channel.sv
// One DSHOT output: serialises a 16-bit frame MSB first, enforces the
// post-frame guard time and holds one pending (last-wins) update.
module dshot_channel
  import dshot_pkg::*;
#(
  parameter int TBIT_CYCLES  = 240,
  parameter int T0H_CYCLES   = 90,
  parameter int T1H_CYCLES   = 180,
  parameter int GUARD_CYCLES = 1200
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               busy_o,
  output logic               pending_o,
  output logic               line_o
);

  localparam int CMAX = (TBIT_CYCLES > GUARD_CYCLES) ? TBIT_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_T0 = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] C_T1 = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] C_TB = CW'(TBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_G  = CW'(GUARD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] shr_q, shr_d;
  logic               pend_q, pend_d;
  logic [VALUE_W-1:0] pval_q, pval_d;
  logic               line_q;

  // Register layout is {telem, throttle}; the wire order is {throttle, telem, crc}.
  function automatic logic [FRAME_W-1:0] mk_frame(input logic [VALUE_W-1:0] r);
    logic [VALUE_W-1:0] v;
    v = {r[10:0], r[11]};
    return {v, dshot_crc(v)};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    pend_d  = pend_q;
    pval_d  = pval_q;

    if (start_i && state_q != S_IDLE) begin
      pend_d = 1'b1;
      pval_d = value_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shr_d   = mk_frame(value_i);
          bit_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (shr_q[FRAME_W-1] ? C_T1 : C_T0)) state_d = S_LOW;
      end
      S_LOW: begin
        if (cnt_q == C_TB) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = S_GUARD;
          end else begin
            bit_d   = bit_q + 4'd1;
            shr_d   = {shr_q[FRAME_W-2:0], 1'b0};
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == C_G) begin
          cnt_d = '0;
          bit_d = 4'd0;
          // A write landing on the last guard cycle is never lost: it either
          // becomes the frame sent now or stays queued behind the old pending.
          if (pend_q) begin
            shr_d   = mk_frame(pval_q);
            pend_d  = start_i;
            state_d = S_HIGH;
          end else if (start_i) begin
            shr_d   = mk_frame(value_i);
            pend_d  = 1'b0;
            state_d = S_HIGH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shr_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      line_q  <= (state_d == S_HIGH);
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign pending_o = pend_q;
  assign line_o    = line_q;

endmodule

// File: rtl/wb_dshot_tx.sv
// Wishbone register front end for NUM_MOTORS DSHOT channels: motor value
// registers, read-only STATUS, single-cycle ack/err with no wait states.
module wb_dshot_tx
  import dshot_pkg::*;
#(
  parameter int NUM_MOTORS   = 4,
  parameter int TBIT_CYCLES  = 240,
  parameter int T0H_CYCLES   = 90,
  parameter int T1H_CYCLES   = 180,
  parameter int GUARD_CYCLES = 1200
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [31:0]           s_wb_adr_i,
  input  logic [31:0]           s_wb_dat_i,
  output logic [31:0]           s_wb_dat_o,
  input  logic                  s_wb_we_i,
  input  logic [3:0]            s_wb_sel_i,
  input  logic                  s_wb_stb_i,
  input  logic                  s_wb_cyc_i,
  output logic                  s_wb_ack_o,
  output logic                  s_wb_err_o,
  output logic [NUM_MOTORS-1:0] o_motor,
  output logic                  o_busy
);

  wb_req_t req;
  logic    req_vld;
  logic    ack_q, err_q;
  logic [31:0] dat_q;

  logic [NUM_MOTORS-1:0][VALUE_W-1:0] motor_q;
  logic [NUM_MOTORS-1:0]              start_q;
  logic [NUM_MOTORS-1:0]              wr_hit;
  logic [NUM_MOTORS-1:0]              busy_w, pend_w;

  logic               hit_motor;
  logic [VALUE_W-1:0] rd_motor;
  logic [7:0]         status;
  logic               unused_ok;

  assign req.we  = s_wb_we_i;
  assign req.idx = s_wb_adr_i[4:2];
  assign req.sel = s_wb_sel_i[1:0];
  assign req.dat = s_wb_dat_i[VALUE_W-1:0];

  assign unused_ok = ^{s_wb_adr_i[31:5], s_wb_adr_i[1:0], s_wb_dat_i[31:VALUE_W],
                       s_wb_sel_i[3:2]};

  // The ack/err gate keeps one response per request despite stb staying high.
  assign req_vld = s_wb_stb_i & s_wb_cyc_i & ~ack_q & ~err_q;

  always_comb begin
    hit_motor = 1'b0;
    rd_motor  = '0;
    wr_hit    = '0;
    for (int n = 0; n < NUM_MOTORS; n++) begin
      if (req.idx == 3'(n)) begin
        hit_motor = 1'b1;
        rd_motor  = motor_q[n];
        wr_hit[n] = req_vld & req.we & (req.sel == 2'b11);
      end
    end
  end

  assign status = {4'(pend_w), 4'(busy_w)};

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      motor_q <= '0;
      start_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= wr_hit;
      for (int n = 0; n < NUM_MOTORS; n++) begin
        if (wr_hit[n]) motor_q[n] <= req.dat;
      end
      if (req_vld) begin
        if (hit_motor) begin
          ack_q <= 1'b1;
          if (!req.we) dat_q <= {{(32-VALUE_W){1'b0}}, rd_motor};
        end else if (req.idx == REG_STATUS && !req.we) begin
          ack_q <= 1'b1;
          dat_q <= {24'd0, status};
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
    dshot_channel #(
      .TBIT_CYCLES  (TBIT_CYCLES),
      .T0H_CYCLES   (T0H_CYCLES),
      .T1H_CYCLES   (T1H_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
    ) u_ch (
      .i_clk     (i_clk),
      .i_resetn  (i_resetn),
      .start_i   (start_q[g]),
      .value_i   (motor_q[g]),
      .busy_o    (busy_w[g]),
      .pending_o (pend_w[g]),
      .line_o    (o_motor[g])
    );
  end

  assign s_wb_ack_o = ack_q;
  assign s_wb_err_o = err_q;
  assign s_wb_dat_o = dat_q;
  assign o_busy     = |busy_w;

endmodule
